seq_event_logger: RTL and testbench

SEQ_EVENT_LOGGER -- requirements
Module: seq_event_logger

---
 rtl/seq_event_logger_if.sv | 30 +++
 rtl/seq_event_logger.sv | 119 +++++++++++
 tb/tb_seq_event_logger.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_event_logger_if.sv
// Event handshake bundle between the sequence event logger (master) and its
// consumer (slave).
//
// Handshake: valid/ready. The master raises evt_valid while the queue head
// holds an event and keeps evt_type/evt_ts stable until the transfer. A
// transfer happens on a rising clk edge where evt_valid & evt_ready are both
// 1. evt_ready may be asserted at any time. It has no effect while evt_valid
// is 0.
interface seq_event_logger_if #(
  parameter int TS_W = 16
) ();
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_type;
  logic [TS_W-1:0] evt_ts;

  modport master (
    output evt_valid,
    output evt_type,
    output evt_ts,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_type,
    input  evt_ts,
    output evt_ready
  );
endinterface

// File: rtl/seq_event_logger.sv
// Sequence event logger: turns detector codes into A/B events and queues them
// in a FIFO with timestamps. It also keeps saturating per-type counters and a
// sticky overflow flag.
// Optional feature: define SEQ_LOG_TIMESTAMP_EN to build the free-running
// timestamp counter and per-entry timestamp storage. When it is undefined,
// evt_ts is tied to 0.
module seq_event_logger #(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         det_code,
  input  logic               clr_stats,
  seq_event_logger_if.master evt,
  output logic [7:0]         cnt_a,
  output logic [7:0]         cnt_b,
  output logic               ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);

  logic [1:0]    prev_code;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          mem_type [FIFO_DEPTH];

  logic is_event;
  logic is_b;
  logic q_empty;
  logic q_full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  // An event is a new pattern code: bit 1 set and different from last cycle.
  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    is_event = det_code[1] & (det_code != prev_code);
    is_b     = det_code[0];
    q_empty  = (occ == '0);
    q_full   = (occ == OCC_FULL);
    do_pop   = ~q_empty & evt.evt_ready;
    do_push  = is_event & (~q_full | do_pop);
    do_drop  = is_event & q_full & ~do_pop;
  end

  // Code history, queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_code <= 2'b00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
    end else begin
      prev_code <= det_code;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Event type storage. Entries are not reset because the output is gated
  // by q_empty.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_type[wr_ptr] <= is_b;
  end

  // Saturating per-type counters. A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      cnt_a <= 8'd0;
      cnt_b <= 8'd0;
    end else if (is_event) begin
      if (!is_b && cnt_a != 8'hFF) cnt_a <= cnt_a + 8'd1;
      if (is_b && cnt_b != 8'hFF)  cnt_b <= cnt_b + 8'd1;
    end
  end

  // Sticky overflow. A clear keeps only a drop from the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (clr_stats) begin
      ovf <= do_drop;
    end else if (do_drop) begin
      ovf <= 1'b1;
    end
  end

  assign evt.evt_valid = ~q_empty;
  assign evt.evt_type  = q_empty ? 1'b0 : mem_type[rd_ptr];

`ifdef SEQ_LOG_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] mem_ts [FIFO_DEPTH];

  // Free-running timestamp. It wraps naturally at 2^TS_W.
  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end

  // Timestamp storage. Each entry captures the counter value of its event cycle.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_ts[wr_ptr] <= ts_cnt;
  end

  assign evt.evt_ts = q_empty ? {TS_W{1'b0}} : mem_ts[rd_ptr];
`else
  assign evt.evt_ts = {TS_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_event_logger.sv
// Testbench for seq_event_logger: directed scenarios followed by a random
// phase. All outputs are compared each cycle against a queue-based reference
// model.
module tb_seq_event_logger;
  localparam int FIFO_DEPTH = 4;
  localparam int TS_W       = 16;
`ifdef SEQ_LOG_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  // clock / reset
  logic       clk;
  logic       reset;
  logic [1:0] det_code;
  logic       clr_stats;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic       ovf;

  seq_event_logger_if #(.TS_W(TS_W)) evt_if ();

  seq_event_logger #(.FIFO_DEPTH(FIFO_DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .det_code  (det_code),
    .clr_stats (clr_stats),
    .evt       (evt_if),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each entry is {type, timestamp}.
  logic [TS_W:0]   exp_q[$];
  int              cnt_a_m;
  int              cnt_b_m;
  bit              ovf_m;
  logic [1:0]      prev_m;
  logic [TS_W-1:0] ts_m;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic          v;
    logic          t;
    logic [TS_W-1:0] ts;
    v  = (exp_q.size() != 0);
    t  = v ? exp_q[0][TS_W] : 1'b0;
    ts = (v && TS_ON) ? exp_q[0][TS_W-1:0] : '0;
    chk({tag, ".valid"}, 32'(evt_if.evt_valid), 32'(v));
    chk({tag, ".type"},  32'(evt_if.evt_type),  32'(t));
    chk({tag, ".ts"},    32'(evt_if.evt_ts),    32'(ts));
    chk({tag, ".cnt_a"}, 32'(cnt_a),            32'(cnt_a_m));
    chk({tag, ".cnt_b"}, 32'(cnt_b),            32'(cnt_b_m));
    chk({tag, ".ovf"},   32'(ovf),              32'(ovf_m));
  endtask

  // Driver: apply one cycle of inputs and advance the model, then compare
  // after the edge.
  task automatic step(input logic [1:0] det, input logic clr, input logic rdy,
                      input logic rst, input string tag);
    bit is_evt;
    bit drop;
    det_code        = det;
    clr_stats       = clr;
    evt_if.evt_ready = rdy;
    reset           = rst;
    if (rst) begin
      exp_q.delete();
      cnt_a_m = 0;
      cnt_b_m = 0;
      ovf_m   = 1'b0;
      prev_m  = 2'b00;
      ts_m    = '0;
    end else begin
      is_evt = det[1] && (det != prev_m);
      drop   = 1'b0;
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (is_evt) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({det[0], ts_m});
        else drop = 1'b1;
      end
      if (clr) begin
        cnt_a_m = 0;
        cnt_b_m = 0;
      end else if (is_evt) begin
        if (!det[0] && cnt_a_m < 255) cnt_a_m++;
        if (det[0] && cnt_b_m < 255)  cnt_b_m++;
      end
      ovf_m  = clr ? drop : (ovf_m | drop);
      prev_m = det;
      ts_m   = ts_m + TS_W'(1);
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    det_code         = 2'b00;
    clr_stats        = 1'b0;
    evt_if.evt_ready = 1'b0;
    reset            = 1'b1;
    exp_q.delete();
    cnt_a_m = 0; cnt_b_m = 0; ovf_m = 1'b0; prev_m = 2'b00; ts_m = '0;

    // Reset state
    step(2'b00, 1'b0, 1'b0, 1'b1, "rst");
    step(2'b10, 1'b0, 1'b1, 1'b1, "rst_evt");
    chk("rst.valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst.ts",    32'(evt_if.evt_ts),    32'd0);
    chk("rst.cnt_a", 32'(cnt_a),            32'd0);
    chk("rst.ovf",   32'(ovf),              32'd0);

    // Single A event at timestamp 5
    for (int i = 0; i < 5; i++) step(2'b00, 1'b0, 1'b0, 1'b0, "idle");
    step(2'b10, 1'b0, 1'b0, 1'b0, "a_ts5");
    chk("a_ts5.valid", 32'(evt_if.evt_valid), 32'd1);
    chk("a_ts5.type",  32'(evt_if.evt_type),  32'd0);
    chk("a_ts5.ts",    32'(evt_if.evt_ts),    TS_ON ? 32'd5 : 32'd0);
    chk("a_ts5.cnt_a", 32'(cnt_a),            32'd1);
    step(2'b00, 1'b0, 1'b1, 1'b0, "a_drain");
    chk("a_drain.valid", 32'(evt_if.evt_valid), 32'd0);

    // Held B code gives one event
    for (int i = 0; i < 4; i++) step(2'b11, 1'b0, 1'b0, 1'b0, "b_hold");
    chk("b_hold.cnt_b", 32'(cnt_b), 32'd1);
    step(2'b00, 1'b0, 1'b1, 1'b0, "b_drain");
    chk("b_drain.valid", 32'(evt_if.evt_valid), 32'd0);

    // Overflow with six alternating events
    step(2'b00, 1'b0, 1'b0, 1'b1, "rst2");
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, 1'b0, "fill6");
    chk("ovf6.ovf",   32'(ovf),   32'd1);
    chk("ovf6.cnt_a", 32'(cnt_a), 32'd3);
    chk("ovf6.cnt_b", 32'(cnt_b), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("ovf6.order", 32'(evt_if.evt_type), 32'(i % 2));
      step(2'b00, 1'b0, 1'b1, 1'b0, "ovf6_drain");
    end
    chk("ovf6.empty", 32'(evt_if.evt_valid), 32'd0);

    // Full queue with simultaneous pop and push
    step(2'b00, 1'b0, 1'b0, 1'b1, "rst3");
    for (int i = 0; i < 4; i++) step((i % 2 == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, 1'b0, "fill4");
    step(2'b10, 1'b0, 1'b1, 1'b0, "full_pp");
    chk("full_pp.ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("full_pp.order", 32'(evt_if.evt_type), 32'((i + 1) % 2));
      step(2'b00, 1'b0, 1'b1, 1'b0, "full_pp_drain");
    end
    chk("full_pp.empty", 32'(evt_if.evt_valid), 32'd0);

    // Saturation, then clear together with an event
    step(2'b00, 1'b0, 1'b0, 1'b1, "rst4");
    for (int i = 0; i < 258; i++) begin
      step(2'b10, 1'b0, 1'b1, 1'b0, "sat_a");
      step(2'b00, 1'b0, 1'b1, 1'b0, "sat_gap");
    end
    chk("sat.cnt_a", 32'(cnt_a), 32'd255);
    step(2'b11, 1'b1, 1'b0, 1'b0, "clr_b");
    chk("clr_b.cnt_a", 32'(cnt_a),            32'd0);
    chk("clr_b.cnt_b", 32'(cnt_b),            32'd0);
    chk("clr_b.ovf",   32'(ovf),              32'd0);
    chk("clr_b.valid", 32'(evt_if.evt_valid), 32'd1);
    chk("clr_b.type",  32'(evt_if.evt_type),  32'd1);
    step(2'b10, 1'b0, 1'b0, 1'b0, "clr_fill");
    step(2'b11, 1'b0, 1'b0, 1'b0, "clr_fill");
    step(2'b10, 1'b0, 1'b0, 1'b0, "clr_fill");
    step(2'b11, 1'b1, 1'b0, 1'b0, "clr_drop");
    chk("clr_drop.ovf",   32'(ovf),   32'd1);
    chk("clr_drop.cnt_b", 32'(cnt_b), 32'd0);
    step(2'b00, 1'b1, 1'b0, 1'b0, "clr_only");
    chk("clr_only.ovf", 32'(ovf), 32'd0);

    // Reset with three events queued
    step(2'b00, 1'b0, 1'b1, 1'b0, "pop1");
    step(2'b00, 1'b0, 1'b0, 1'b1, "rst_q");
    chk("rst_q.valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_q.type",  32'(evt_if.evt_type),  32'd0);
    chk("rst_q.ts",    32'(evt_if.evt_ts),    32'd0);
    chk("rst_q.cnt_a", 32'(cnt_a),            32'd0);
    chk("rst_q.cnt_b", 32'(cnt_b),            32'd0);
    chk("rst_q.ovf",   32'(ovf),              32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 79) == 0),
           "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
